// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the IF (fetch) and MEM (load/store) stages.
// MEM has priority; a starvation guard forces an IF grant after STARVE_MAX MEM grants.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int unsigned MADDR_L    = 32,
    parameter int unsigned DATA_L     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_re,
    input  logic [MADDR_L-1:0] if_addr,
    input  logic [1:0]         if_rlen,
    output logic               if_rack,
    output logic [DATA_L-1:0]  if_data,
    input  logic               mem_re,
    input  logic               mem_we,
    input  logic [MADDR_L-1:0] mem_addr,
    input  logic [1:0]         mem_len,
    input  logic [DATA_L-1:0]  mem_wdata,
    output logic               mem_rack,
    output logic               mem_wack,
    output logic [DATA_L-1:0]  mem_rdata,
    output logic               m_re,
    output logic               m_we,
    output logic [MADDR_L-1:0] m_addr,
    output logic [1:0]         m_len,
    output logic [DATA_L-1:0]  m_wdata,
    input  logic [DATA_L-1:0]  m_rdata,
    input  logic               m_ack,
    output logic               busy,
    output logic               err_timeout
);

    localparam logic [3:0] StarveMax  = 4'(STARVE_MAX);
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StGntIf, StGntMem, StDone} state_e;

    state_e               state_q, state_d;
    logic [3:0]           starve_q, starve_d;
    logic [7:0]           tmo_q, tmo_d;
    logic                 err_q, err_d;
    logic                 m_re_q, m_re_d, m_we_q, m_we_d;
    logic [MADDR_L-1:0]   m_addr_q, m_addr_d;
    logic [1:0]           m_len_q, m_len_d;
    logic [DATA_L-1:0]    m_wdata_q, m_wdata_d;
    logic [DATA_L-1:0]    if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
    logic                 if_rack_q, if_rack_d, mem_rack_q, mem_rack_d, mem_wack_q, mem_wack_d;
    logic                 grant_if, grant_mem;

    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state_q == StIdle) begin
            if (if_re && starve_q == StarveMax) begin
                grant_if = 1'b1;
            end else if (mem_we || mem_re) begin
                grant_mem = 1'b1;
            end else if (if_re) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        m_re_d      = m_re_q;
        m_we_d      = m_we_q;
        m_addr_d    = m_addr_q;
        m_len_d     = m_len_q;
        m_wdata_d   = m_wdata_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_rack_d   = 1'b0;
        mem_rack_d  = 1'b0;
        mem_wack_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_if) begin
                    state_d  = StGntIf;
                    m_addr_d = if_addr;
                    m_len_d  = if_rlen;
                    m_re_d   = 1'b1;
                    m_we_d   = 1'b0;
                    tmo_d    = '0;
                    starve_d = '0;
                end else if (grant_mem) begin
                    state_d  = StGntMem;
                    m_addr_d = mem_addr;
                    m_len_d  = mem_len;
                    // A simultaneous load and store is treated as a store only.
                    m_we_d   = mem_we;
                    m_re_d   = ~mem_we;
                    tmo_d    = '0;
                    if (mem_we) begin
                        m_wdata_d = mem_wdata;
                    end
                    if (!if_re) begin
                        starve_d = '0;
                    end else if (starve_q != StarveMax) begin
                        starve_d = starve_q + 4'd1;
                    end
                end
            end
            StGntIf, StGntMem: begin
                if (m_ack) begin
                    state_d = StDone;
                    m_re_d  = 1'b0;
                    m_we_d  = 1'b0;
                    if (state_q == StGntIf) begin
                        if_rack_d = 1'b1;
                        if_data_d = m_rdata;
                    end else if (m_we_q) begin
                        mem_wack_d = 1'b1;
                    end else begin
                        mem_rack_d  = 1'b1;
                        mem_rdata_d = m_rdata;
                    end
                end else if (tmo_q != TimeoutCnt) begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_q + 8'd1 == TimeoutCnt) begin
                        err_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            m_re_q      <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_len_q     <= '0;
            m_wdata_q   <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_rack_q   <= 1'b0;
            mem_rack_q  <= 1'b0;
            mem_wack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            m_re_q      <= m_re_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_len_q     <= m_len_d;
            m_wdata_q   <= m_wdata_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_rack_q   <= if_rack_d;
            mem_rack_q  <= mem_rack_d;
            mem_wack_q  <= mem_wack_d;
        end
    end

    assign m_re        = m_re_q;
    assign m_we        = m_we_q;
    assign m_addr      = m_addr_q;
    assign m_len       = m_len_q;
    assign m_wdata     = m_wdata_q;
    assign if_data     = if_data_q;
    assign mem_rdata   = mem_rdata_q;
    assign if_rack     = if_rack_q;
    assign mem_rack    = mem_rack_q;
    assign mem_wack    = mem_wack_q;
    assign busy        = (state_q != StIdle);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: requester/memory models feed a scoreboard queue
// that a monitor drains on every ack pulse.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_re, if_rack, mem_re, mem_we, mem_rack, mem_wack;
    logic        m_re, m_we, m_ack, busy, err_timeout;
    logic [31:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  if_rlen, mem_len, m_len;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MADDR_L   (32),
        .DATA_L    (32),
        .STARVE_MAX(4),
        .TIMEOUT   (255)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_re      (if_re),
        .if_addr    (if_addr),
        .if_rlen    (if_rlen),
        .if_rack    (if_rack),
        .if_data    (if_data),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_len    (mem_len),
        .mem_wdata  (mem_wdata),
        .mem_rack   (mem_rack),
        .mem_wack   (mem_wack),
        .mem_rdata  (mem_rdata),
        .m_re       (m_re),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_len      (m_len),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_ack      (m_ack),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    // kind: 0 = if_rack, 1 = mem_rack, 2 = mem_wack
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Memory model: acks ack_lat cycles after the strobe appears, data = {addr[15:0], 0x0013}.
    int ack_lat  = 2;
    bit hold_ack = 1'b0;
    int wait_cnt = 0;
    initial begin
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            m_ack = 1'b0;
            if ((m_re || m_we) && !hold_ack) begin
                if (wait_cnt >= ack_lat) begin
                    m_ack    = 1'b1;
                    m_rdata  = {m_addr[15:0], 16'h0013};
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (!(m_re || m_we)) begin
                wait_cnt = 0;
            end
        end
    end

    // Requesters: hold the level request while transactions remain, count down on acks.
    int if_count  = 0;
    int mem_count = 0;
    bit mem_rd    = 1'b1;
    bit mem_st    = 1'b0;
    initial begin
        if_re  = 1'b0;
        mem_re = 1'b0;
        mem_we = 1'b0;
        forever begin
            @(negedge clk);
            if (if_rack && if_count > 0) if_count--;
            if ((mem_rack || mem_wack) && mem_count > 0) mem_count--;
            if_re  = (if_count > 0);
            mem_re = (mem_count > 0) && mem_rd;
            mem_we = (mem_count > 0) && mem_st;
        end
    end

    // Monitor: every ack pulse pops one expected transaction.
    initial begin
        logic ack_prev;
        int   kind;
        exp_t e;
        forever begin
            @(posedge clk);
            ack_prev = m_ack;
            @(negedge clk);
            if (if_rack || mem_rack || mem_wack) begin
                kind = if_rack ? 0 : (mem_rack ? 1 : 2);
                check("ack_onehot", 32'(if_rack) + 32'(mem_rack) + 32'(mem_wack), 32'd1);
                check("ack_follows_m_ack", 32'(ack_prev), 32'd1);
                check("strobe_dropped", 32'({m_re, m_we}), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: kind %0d seen, none expected", kind);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_kind", 32'(kind), 32'(e.kind));
                    check("ack_addr", m_addr, e.addr);
                    if (kind == 0) check("if_data", if_data, e.data);
                    if (kind == 1) check("mem_rdata", mem_rdata, e.data);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 2000) begin
            bad++;
            $display("FAIL %s_drain: timed out with %0d pending, want 0", name, exp_q.size());
        end
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(m_re || m_we) && n < 100);
        total++;
        if (!(m_re || m_we)) begin
            bad++;
            $display("FAIL %s_strobe: strobe 0 after %0d cycles, want 1", name, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        if_addr   = '0;
        if_rlen   = '0;
        mem_addr  = '0;
        mem_len   = '0;
        mem_wdata = '0;
        #12;
        check("rst_strobes", 32'({m_re, m_we}), 32'd0);
        check("rst_acks", 32'({if_rack, mem_rack, mem_wack}), 32'd0);
        check("rst_busy_err", 32'({busy, err_timeout}), 32'd0);
        check("rst_data", if_data | mem_rdata, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // IF only, memory acks 2 cycles after the strobe
        ack_lat = 2;
        @(posedge clk);
        #1;
        if_addr  = 32'h1000;
        if_rlen  = 2'd3;
        push(0, 32'h1000, 32'h1000_0013);
        if_count = 1;
        @(negedge clk);
        #1;
        check("t1_no_strobe_yet", 32'(m_re), 32'd0);
        @(negedge clk);
        #1;
        check("t1_m_re", 32'(m_re), 32'd1);
        check("t1_m_addr", m_addr, 32'h1000);
        check("t1_m_len", 32'(m_len), 32'd3);
        check("t1_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("t1_if_rack", 32'(if_rack), 32'd1);
        check("t1_if_data", if_data, 32'h1000_0013);
        @(negedge clk);
        #1;
        check("t1_rack_pulse", 32'(if_rack), 32'd0);
        check("t1_busy_low", 32'(busy), 32'd0);
        wait_drain("t1");

        // Collision, memory acks in the first strobe cycle
        ack_lat = 0;
        @(posedge clk);
        #1;
        if_addr   = 32'h1004;
        mem_addr  = 32'h2000;
        mem_len   = 2'd3;
        mem_rd    = 1'b1;
        mem_st    = 1'b0;
        push(1, 32'h2000, 32'h2000_0013);
        push(0, 32'h1004, 32'h1004_0013);
        if_count  = 1;
        mem_count = 1;
        wait_drain("collision");

        // Starvation: 4 MEM grants, then IF, then MEM resumes
        ack_lat = 1;
        @(posedge clk);
        #1;
        if_addr  = 32'h1008;
        mem_addr = 32'h3000;
        for (int i = 0; i < 4; i++) push(1, 32'h3000, 32'h3000_0013);
        push(0, 32'h1008, 32'h1008_0013);
        for (int i = 0; i < 2; i++) push(1, 32'h3000, 32'h3000_0013);
        if_count  = 1;
        mem_count = 6;
        wait_drain("starve");

        // Store wins over a simultaneous load
        @(posedge clk);
        #1;
        mem_addr  = 32'h5000;
        mem_wdata = 32'hDEAD_BEEF;
        mem_rd    = 1'b1;
        mem_st    = 1'b1;
        push(2, 32'h5000, 32'h0);
        mem_count = 1;
        wait_strobe("store");
        check("store_m_we", 32'(m_we), 32'd1);
        check("store_m_re", 32'(m_re), 32'd0);
        check("store_m_wdata", m_wdata, 32'hDEAD_BEEF);
        wait_drain("store");
        check("store_rdata_kept", mem_rdata, 32'h3000_0013);
        mem_st = 1'b0;

        // Timeout: ack withheld ~300 cycles
        hold_ack = 1'b1;
        @(posedge clk);
        #1;
        if_addr = 32'h100C;
        push(0, 32'h100C, 32'h100C_0013);
        if_count = 1;
        wait_strobe("tmo");
        repeat (254) @(negedge clk);
        #1;
        check("tmo_err_before", 32'(err_timeout), 32'd0);
        @(negedge clk);
        #1;
        check("tmo_err_set", 32'(err_timeout), 32'd1);
        repeat (44) @(negedge clk);
        #1;
        check("tmo_err_sticky", 32'(err_timeout), 32'd1);
        check("tmo_strobe_held", 32'(m_re), 32'd1);
        hold_ack = 1'b0;
        wait_drain("tmo");
        check("tmo_err_after_ack", 32'(err_timeout), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("tmo_err_cleared", 32'(err_timeout), 32'd0);
        check("tmo_if_data_cleared", if_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a MEM load: abandoned, no ack
        hold_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_addr  = 32'h4000;
        mem_rd    = 1'b1;
        mem_count = 1;
        wait_strobe("rstmid");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_strobe", 32'({m_re, m_we}), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_m_addr", m_addr, 32'd0);
        check("rstmid_mem_rdata", mem_rdata, 32'd0);
        mem_count = 0;
        hold_ack  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("rstmid_idle", 32'(busy), 32'd0);
        check("rstmid_no_strobe", 32'({m_re, m_we}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the IF stage (instruction read only) and the MEM stage (data load/store).
- Fixed priority to MEM, with a starvation guard that forces an IF grant after STARVE_MAX consecutive MEM grants while IF is waiting.
- Sits between the pipeline stages and the memory controller.
- Converts the stages' level request / ack pulse handshakes into one serialized memory transaction stream, with sticky timeout detection.

Parameters:
- MADDR_L, 32, memory address width.
- DATA_L, 32, data width.
- STARVE_MAX, 4, consecutive MEM grants allowed while if_re is pending; range 1..15.
- TIMEOUT, 255, cycles to wait for m_ack before raising err_timeout; 8-bit counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_re  in  1  IF read request; level, held until if_rack.
- if_addr  in  MADDR_L  IF fetch address.
- if_rlen  in  2  IF read length code (0=byte, 1=half, 3=word).
- if_rack  out  1  one-cycle pulse: if_data valid.
- if_data  out  DATA_L  registered IF read data.
- mem_re  in  1  MEM load request; level.
- mem_we  in  1  MEM store request; level.
- mem_addr  in  MADDR_L  MEM address.
- mem_len  in  2  MEM length code.
- mem_wdata  in  DATA_L  store data.
- mem_rack  out  1  one-cycle pulse: load complete, mem_rdata valid.
- mem_wack  out  1  one-cycle pulse: store complete.
- mem_rdata  out  DATA_L  registered load data.
- m_re  out  1  memory read strobe, held until m_ack.
- m_we  out  1  memory write strobe, held until m_ack.
- m_addr  out  MADDR_L  latched transaction address.
- m_len  out  2  latched length code.
- m_wdata  out  DATA_L  latched write data.
- m_rdata  in  DATA_L  memory read data; valid in the m_ack cycle.
- m_ack  in  1  memory completion pulse.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  sticky; set on timeout, cleared only by rst.

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - All outputs 0; if_data and mem_rdata are 0.
  - Starvation counter and timeout counter are 0.
  - Any in-flight transaction is abandoned; no ack is issued for it.
- States: IDLE, GNT_IF, GNT_MEM, DONE.
- IDLE, evaluated each cycle:
  - Starvation override: if if_re and starve_cnt==STARVE_MAX, grant IF.
  - Else if mem_we or mem_re, grant MEM.
  - Else if if_re, grant IF.
  - Else stay in IDLE.
- On a grant:
  - Latch address, length and (MEM store only) wdata into m_* registers.
  - Assert m_re or m_we on the next cycle. Request seen in cycle N gives the strobe in cycle N+1.
  - Clear the timeout counter.
- MEM with mem_re and mem_we both high: store wins (m_we=1, m_re=0). Only mem_wack is returned.
- starve_cnt update at each grant decision:
  - MEM grant while if_re high: starve_cnt+1, saturating at STARVE_MAX.
  - IF grant: starve_cnt=0.
  - MEM grant with if_re low: starve_cnt=0.
- GNT_IF / GNT_MEM:
  - Hold the strobe and latched fields stable until m_ack.
  - The timeout counter increments each cycle without m_ack. When it reaches TIMEOUT, set err_timeout and keep waiting; the counter saturates.
- On m_ack in cycle M:
  - Strobe drops in cycle M+1.
  - Return data is registered: if_data/mem_rdata take m_rdata.
  - The matching ack pulses high for exactly cycle M+1.
  - Go to DONE.
- DONE (1 cycle): requests are ignored so the acked requester can drop its level request; then IDLE. Minimum turnaround is ack pulse, DONE, then a new grant decision.
- Requester drops its request before m_ack: the transaction still completes and the ack is still pulsed. The requester must tolerate this.
- m_ack in IDLE or DONE: ignored, no ack generated.
- m_ack in the same cycle the strobe is first asserted: legal; completes normally.
- if_data and mem_rdata hold their value until the next completing read for that requester.
- Only one of if_rack/mem_rack/mem_wack is ever high in a cycle.

Test Plan:
- IF only: if_re=1, if_addr=0x1000; memory acks 2 cycles after m_re → m_re=1 with m_addr=0x1000 one cycle after the request; if_rack pulses 1 cycle after m_ack with if_data=m_rdata (e.g. 0x00000013); busy low again 2 cycles after the ack.
- Collision: if_re and mem_re rise together (if_addr=0x1004, mem_addr=0x2000) → first transaction m_addr=0x2000 with mem_rack; next grant m_addr=0x1004 with if_rack; starve_cnt=1 at the IF grant, then 0.
- Starvation: if_re held, mem_re re-asserted immediately after each ack, STARVE_MAX=4 → exactly 4 MEM transactions, then the IF transaction, then MEM resumes.
- Store precedence: mem_re=mem_we=1, mem_wdata=0xDEADBEEF → m_we=1, m_re=0, m_wdata=0xDEADBEEF; only mem_wack pulses, mem_rack stays 0.
- Timeout: grant with m_ack withheld 300 cycles → err_timeout=1 in the strobe cycle +255 and stays 1; a late m_ack still completes with an ack pulse; err_timeout clears only on rst.
- Reset mid-transaction: assert rst while m_re=1 → all outputs 0 immediately (asynchronous); after release with no requests, no ack pulses and state IDLE (busy=0).
